gelato_ram_arbiter: RTL and testbench
=====================================

# gelato_ram_arbiter

Round-robin arbiter that shares the single RAM port among `NUM_REQ` requesters, such as the L1 instruction cache and L1 data cache. It sits between the L1 caches and RAM. Each requester holds a request until it is served, and the RAM port carries one transaction at a time. Returned data is registered and routed back to the granted requester as a one-cycle done pulse.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; must be at least 2.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`, input, 1: clock; all logic is on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `rdy`, input, 1: global enable; when low, all state holds.
- `req_valid`, input, `NUM_REQ`: per-requester request; held high until that requester's `req_done`.
- `req_addr`, input, `NUM_REQ*ADDR_W`: packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]; stable while `req_valid[i]`.
- `req_done`, output, `NUM_REQ`: one-hot, one-cycle completion pulse.
- `req_data`, output, `DATA_W`: response data; valid only while some `req_done` bit is high.
- `ram_valid`, output, 1: RAM request; held until `ram_done`.
- `ram_addr`, output, `ADDR_W`: RAM address; stable while `ram_valid` is high.
- `ram_done`, input, 1: RAM completion pulse.
- `ram_data`, input, `DATA_W`: RAM data; sampled on the cycle `ram_done` is high.
- `perf_grant_cnt`, output, `NUM_REQ*32`: per-requester grant counters (see Configuration).

## Operation
- State machine has three states: IDLE, BUSY, RESPOND.
- IDLE:
  - `ram_valid`=0 and `req_done`=0.
  - If any `req_valid` bit is high, search from `rr_ptr` upward with wrap for the first set bit g.
  - Latch g into `grant` and `req_addr[g]` into `addr_q`, then go to BUSY.
  - If no bit is set, stay in IDLE.
- BUSY:
  - `ram_valid`=1 and `ram_addr`=`addr_q`.
  - On `ram_done`, latch `ram_data` into `data_q` and go to RESPOND.
- RESPOND:
  - `req_done[grant]`=1, `req_data`=`data_q`, `ram_valid`=0.
  - Set `rr_ptr` = (`grant`+1) mod `NUM_REQ`, then go to IDLE.
- `rr_ptr` is `$clog2(NUM_REQ)` bits wide. Wrap from `NUM_REQ`-1 to 0 is explicit, and correct for `NUM_REQ` values that are not a power of two.
- `req_data` is 0 whenever `req_done` is 0.
- `ram_done` outside BUSY is ignored.
- `req_valid` changes on requesters that are not granted have no effect until the next IDLE.
- A requester that drops `req_valid` while granted does not abort the transaction; the done pulse is still issued.
- When `rdy`=0, state, `rr_ptr`, latches and counters hold, and outputs keep their current values.
- A `ram_done` that arrives while `rdy`=0 is lost. RAM must not complete while `rdy` is low.

## Timing
- Reset values:
  - state = IDLE, `rr_ptr`=0, `grant`=0.
  - `addr_q`=0, `data_q`=0.
  - `ram_valid`=0, `ram_addr`=0, `req_done`=0, `req_data`=0, `perf_grant_cnt`=0.
- Reset during BUSY or RESPOND abandons the transaction with no done pulse. A late `ram_done` that follows is ignored.
- Minimum latency (`ram_done` in the first BUSY cycle):
  - `req_valid` seen in IDLE at cycle 0.
  - `ram_valid` high in cycle 1.
  - `req_done` in cycle 2.
  - Next grant decision in cycle 3.
- Latency is 2 + (RAM wait cycles).
- RAM throughput is one transaction per 3 cycles at best.
- Requesters update `req_valid`/`req_addr` at the edge that ends their done cycle. IDLE samples the new value.

## Configuration
- Macro `GELATO_RAM_ARB_PERF_EN`.
- When defined: in RESPOND, when `rdy` is high, counter[`grant`] increments by 1. The counter is 32 bits and wraps from 0xFFFFFFFF to 0.
- When undefined: no counter registers exist, and `perf_grant_cnt` is tied to 0.

## Test plan
- Single request:
  - Stimulus: `req_valid`=2'b01, addr 0x100; `ram_done` with data 0xDEADBEEF one cycle after `ram_valid` rises.
  - Required: `ram_addr`=0x100; `req_done`=2'b01 with `req_data`=0xDEADBEEF exactly 2 cycles after the request is sampled.
- Contention:
  - Stimulus: both requesters valid continuously from reset, addr0=0x10, addr1=0x20.
  - Required: grants alternate 0,1,0,1; `ram_addr` sequence is 0x10, 0x20, 0x10, 0x20.
- Pointer wrap with `NUM_REQ`=3:
  - Stimulus: after granting requester 2, only requester 0 is valid.
  - Required: requester 0 is granted; `rr_ptr` becomes 1.
- `rdy` stall:
  - Stimulus: drop `rdy` for 4 cycles while in BUSY.
  - Required: `ram_valid`/`ram_addr` hold; after `rdy` returns, the done pulse appears normally and exactly once.
- Reset mid-BUSY:
  - Stimulus: assert `rst_n`=0 for one cycle during BUSY, then pulse `ram_done`.
  - Required: all outputs go to 0; no `req_done`; the arbiter stays in IDLE.
- Performance counters, with `GELATO_RAM_ARB_PERF_EN` defined:
  - Stimulus: 5 grants to requester 0 and 3 to requester 1.
  - Required: counter0 = 5, counter1 = 3.
  - Without the macro: both counters read 0.

Source files
------------

// File: rtl/gelato_ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters (IDLE/BUSY/RESPOND).
// Optional per-requester grant counters are enabled by defining GELATO_RAM_ARB_PERF_EN.
module gelato_ram_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         req_data,
  output logic                      ram_valid,
  output logic [ADDR_W-1:0]         ram_addr,
  input  logic                      ram_done,
  input  logic [DATA_W-1:0]         ram_data,
  output logic [NUM_REQ*32-1:0]     perf_grant_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [PTR_W-1:0]   pick;
  logic               found;
  int                 idx;

  // Handshakes: req_valid[i] stays high until req_done[i]; ram_valid stays
  // high (with stable ram_addr) until ram_done, which only counts in BUSY with rdy high.

  // Round-robin search starting at rr_ptr with explicit wrap at NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            grant_d = pick;
            addr_d  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
            state_d = S_BUSY;
          end
        end
        S_BUSY: begin
          if (ram_done) begin
            data_d  = ram_data;
            state_d = S_RESPOND;
          end
        end
        S_RESPOND: begin
          rr_ptr_d = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Outputs decode only registered state, so they hold whenever rdy is low.
  always_comb begin
    ram_valid = (state_q == S_BUSY);
    ram_addr  = addr_q;
    req_done  = '0;
    req_data  = '0;
    if (state_q == S_RESPOND) begin
      req_done[grant_q] = 1'b1;
      req_data          = data_q;
    end
  end

`ifdef GELATO_RAM_ARB_PERF_EN
  logic [31:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (rdy && state_q == S_RESPOND) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    assign perf_grant_cnt[gi*32 +: 32] = cnt_q[gi];
  end
`else
  assign perf_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_gelato_ram_arbiter.sv
// Bench for gelato_ram_arbiter (NUM_REQ=3): directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level model.
module tb_gelato_ram_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rdy;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_done;
  logic [DW-1:0]   req_data;
  logic            ram_valid;
  logic [AW-1:0]   ram_addr;
  logic            ram_done;
  logic [DW-1:0]   ram_data;
  logic [N*32-1:0] perf_grant_cnt;

  gelato_ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_done(req_done), .req_data(req_data),
    .ram_valid(ram_valid), .ram_addr(ram_addr),
    .ram_done(ram_done), .ram_data(ram_data),
    .perf_grant_cnt(perf_grant_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_phase = 0;  // 0 waiting for a request, 1 RAM access open, 2 answering
  int          m_grant = 0;
  int          m_ptr   = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [31:0] m_cnt [N];
  logic [31:0] exp_c;

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_grant <= 0;
      m_ptr   <= 0;
      m_addr  <= '0;
      m_data  <= '0;
      for (int i = 0; i < N; i++) m_cnt[i] <= '0;
    end else if (rdy) begin
      case (m_phase)
        0: if (req_valid != '0) begin
             m_grant <= pick(m_ptr, req_valid);
             m_addr  <= req_addr[pick(m_ptr, req_valid)*AW +: AW];
             m_phase <= 1;
           end
        1: if (ram_done) begin
             m_data  <= ram_data;
             m_phase <= 2;
           end
        default: begin
          m_cnt[m_grant] <= m_cnt[m_grant] + 32'd1;
          m_ptr          <= (m_grant + 1) % N;
          m_phase        <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ram_valid", ram_valid, (m_phase == 1));
      if (m_phase == 1) chk("ram_addr", ram_addr, m_addr);
      chk("req_done", req_done, (m_phase == 2) ? (64'd1 << m_grant) : 64'd0);
      chk("req_data", req_data, (m_phase == 2) ? m_data : '0);
      for (int i = 0; i < N; i++) begin
`ifdef GELATO_RAM_ARB_PERF_EN
        exp_c = m_cnt[i];
`else
        exp_c = '0;
`endif
        chk("perf_cnt", perf_grant_cnt[i*32 +: 32], exp_c);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_addr(input int r, input logic [AW-1:0] a);
    req_addr[r*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic txn(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d, input int w);
    req_valid[r] = 1'b1;
    set_addr(r, a);
    tick();
    repeat (w) tick();
    ram_done = 1'b1;
    ram_data = d;
    tick();
    ram_done = 1'b0;
    req_valid[r] = 1'b0;
    tick();
  endtask

  logic [AW-1:0] addr_seq[$];
  int            n;
  logic [N-1:0]  seen_done;
  int            exp0, exp1;

  initial begin
    rst_n = 1'b0; rdy = 1'b1; req_valid = '0; req_addr = '0;
    ram_done = 1'b0; ram_data = '0;
    tick();
    cmp_en = 1'b1;
    sample();
    chk("reset_ram_valid", ram_valid, 0);
    chk("reset_ram_addr", ram_addr, 0);
    chk("reset_req_done", req_done, 0);
    chk("reset_req_data", req_data, 0);
    chk("reset_perf", perf_grant_cnt, 0);
    rst_n = 1'b1;
    tick();

    // single request, RAM answers in the first BUSY cycle
    req_valid = 3'b001;
    set_addr(0, 32'h100);
    tick();
    ram_done = 1'b1; ram_data = 32'hDEADBEEF;
    sample();
    chk("single_ram_valid", ram_valid, 1);
    chk("single_ram_addr", ram_addr, 32'h100);
    tick();
    ram_done = 1'b0; req_valid = '0;
    sample();
    chk("single_req_done", req_done, 3'b001);
    chk("single_req_data", req_data, 32'hDEADBEEF);
    tick();
    sample();
    chk("single_done_cleared", req_done, 0);

    // contention between requesters 0 and 1
    do_reset();
    req_valid = 3'b011;
    set_addr(0, 32'h10); set_addr(1, 32'h20);
    ram_done = 1'b1; ram_data = 32'h5A5A;
    addr_seq.delete();
    for (int c = 0; c < 12; c++) begin
      sample();
      if (ram_valid) addr_seq.push_back(ram_addr);
      tick();
      if (c == 11) req_valid = '0;
    end
    ram_done = 1'b0;
    chk("contention_count", addr_seq.size(), 4);
    if (addr_seq.size() == 4) begin
      chk("contention_addr0", addr_seq[0], 32'h10);
      chk("contention_addr1", addr_seq[1], 32'h20);
      chk("contention_addr2", addr_seq[2], 32'h10);
      chk("contention_addr3", addr_seq[3], 32'h20);
    end
    tick();

    // pointer wrap after granting the last requester
    do_reset();
    req_valid = 3'b100; set_addr(2, 32'h300);
    ram_done = 1'b1; ram_data = 32'h33;
    tick();                               // now BUSY for requester 2
    tick();                               // RESPOND
    req_valid = 3'b001; set_addr(0, 32'h30);
    tick();                               // IDLE
    tick();                               // BUSY for requester 0
    sample();
    chk("wrap_ram_addr", ram_addr, 32'h30);
    tick();
    sample();
    chk("wrap_req_done", req_done, 3'b001);
    req_valid = 3'b011; set_addr(1, 32'h31);
    tick();                               // IDLE, rr_ptr now 1
    tick();
    sample();
    chk("wrap_ptr_next_addr", ram_addr, 32'h31);
    tick();
    sample();
    chk("wrap_ptr_next_done", req_done, 3'b010);
    ram_done = 1'b0; req_valid = '0;
    tick();

    // rdy stall during BUSY; granted requester also drops its request
    do_reset();
    req_valid = 3'b010; set_addr(1, 32'h55);
    tick();
    rdy = 1'b0; req_valid = '0;
    repeat (4) begin
      sample();
      chk("stall_ram_valid", ram_valid, 1);
      chk("stall_ram_addr", ram_addr, 32'h55);
      chk("stall_req_done", req_done, 0);
      tick();
    end
    rdy = 1'b1; ram_done = 1'b1; ram_data = 32'h1234;
    tick();
    ram_done = 1'b0;
    sample();
    chk("stall_req_done", req_done, 3'b010);
    chk("stall_req_data", req_data, 32'h1234);
    tick();
    n = 0;
    repeat (5) begin
      sample();
      if (req_done != '0) n++;
      tick();
    end
    chk("stall_extra_done", n, 0);

    // reset while BUSY, then a late ram_done
    req_valid = 3'b001; set_addr(0, 32'h77);
    tick();
    sample();
    chk("rstbusy_ram_valid", ram_valid, 1);
    rst_n = 1'b0; req_valid = '0;
    tick();
    rst_n = 1'b1; ram_done = 1'b1; ram_data = 32'hAA;
    sample();
    chk("rstbusy_ram_valid0", ram_valid, 0);
    chk("rstbusy_ram_addr0", ram_addr, 0);
    chk("rstbusy_req_done0", req_done, 0);
    chk("rstbusy_req_data0", req_data, 0);
    tick();
    ram_done = 1'b0;
    n = 0;
    repeat (4) begin
      sample();
      if (req_done != '0 || ram_valid) n++;
      tick();
    end
    chk("rstbusy_quiet", n, 0);

    // grant counters: 5 to requester 0, 3 to requester 1
    do_reset();
    for (int i = 0; i < 8; i++) begin
      txn((i < 6) ? (i % 2) : 0, 32'h1000 + i, 32'hC000 + i, $urandom_range(0, 3));
    end
`ifdef GELATO_RAM_ARB_PERF_EN
    exp0 = 5; exp1 = 3;
`else
    exp0 = 0; exp1 = 0;
`endif
    sample();
    chk("perf_counter0", perf_grant_cnt[31:0], exp0);
    chk("perf_counter1", perf_grant_cnt[63:32], exp1);
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      sample();
      seen_done = req_done;
      n = ram_valid ? 1 : 0;
      tick();
      for (int i = 0; i < N; i++) begin
        if (seen_done[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          set_addr(i, $urandom);
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          set_addr(i, $urandom);
        end
      end
      ram_done = (n == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      ram_data = $urandom;
      rdy      = ($urandom_range(0, 7) != 0);
      rst_n    = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1; rdy = 1'b1; ram_done = 1'b0; req_valid = '0;
    repeat (3) tick();
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
